// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and helpers for the MIPS data-memory access master.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [3:0] {
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_SB, OP_SH, OP_SW
    } mem_op_t;

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, DONE, ERR
    } state_t;

    localparam logic [3:0] BE_ALL = 4'b1111;

    function automatic logic op_is_store(input mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // LWL/LWR and byte accesses can never be misaligned
    function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] k);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: bad = k[0];
            OP_LW, OP_SW:         bad = (k != 2'b00);
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Purpose  : Extracts, extends or merges the bus read word into a load result.
// Revision : 1.0 - initial release
// ============================================================================
module load_align
    import mem_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  k,
    input  logic [31:0] readdata,
    input  logic [31:0] rt_old,
    output logic [31:0] load_result
);

    localparam logic [31:0] c_ONES = 32'hFFFF_FFFF;

    logic [4:0]  w_sh_k;
    logic [4:0]  w_sh_inv;
    logic [15:0] w_lane;

    assign w_sh_k   = {k, 3'b000};
    assign w_sh_inv = {~k, 3'b000};
    assign w_lane   = 16'(readdata >> w_sh_k);

    // LWL/LWR keep the rt bytes the unaligned word does not cover
    always_comb begin
        load_result = readdata;
        case (op)
            OP_LB:   load_result = {{24{w_lane[7]}}, w_lane[7:0]};
            OP_LBU:  load_result = {24'h000000, w_lane[7:0]};
            OP_LH:   load_result = {{16{w_lane[15]}}, w_lane};
            OP_LHU:  load_result = {16'h0000, w_lane};
            OP_LWL:  load_result = (readdata << w_sh_inv) | (rt_old & ~(c_ONES << w_sh_inv));
            OP_LWR:  load_result = (readdata >> w_sh_k) | (rt_old & ~(c_ONES >> w_sh_k));
            default: load_result = readdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_master
// Purpose  : Turns one MIPS load/store request into one byte-lane RAM bus access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_master
    import mem_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  mem_op_t     op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rt_old,
    output logic        busy,
    output logic        done,
    output logic        addr_error,
    output logic [31:0] load_result,
    output logic [31:0] address,
    output logic [3:0]  byteenable,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    localparam logic [1:0] c_LAT_LAST = 2'(READ_LATENCY - 1);

    state_t      r_state;
    state_t      w_next;
    mem_op_t     r_op;
    logic [1:0]  r_k;
    logic [1:0]  r_cnt;
    logic [31:0] r_rt_old;
    logic [31:0] r_address;
    logic [3:0]  r_byteenable;
    logic [31:0] r_writedata;
    logic [31:0] r_load_result;
    logic [31:0] w_aligned;
    logic [3:0]  w_be;
    logic        w_last;

    assign w_last      = (r_state == WAIT) && (r_cnt == c_LAT_LAST);
    assign address     = r_address;
    assign byteenable  = r_byteenable;
    assign writedata   = r_writedata;
    assign load_result = r_load_result;

    always_comb begin
        w_be = BE_ALL;
        case (op)
            OP_LB, OP_LBU, OP_SB: w_be = 4'b0001 << addr[1:0];
            OP_LH, OP_LHU, OP_SH: w_be = addr[1] ? 4'b1100 : 4'b0011;
            OP_LWL:               w_be = BE_ALL >> ~addr[1:0];
            OP_LWR:               w_be = BE_ALL << addr[1:0];
            default:              w_be = BE_ALL;
        endcase
    end

    // Bus outputs are captured once at start so they stay stable under waitrequest
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_op          <= OP_LB;
            r_k           <= 2'b00;
            r_cnt         <= 2'b00;
            r_rt_old      <= '0;
            r_address     <= '0;
            r_byteenable  <= '0;
            r_writedata   <= '0;
            r_load_result <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == WAIT) ? r_cnt + 2'd1 : 2'd0;
            if ((r_state == IDLE) && start) begin
                r_op         <= op;
                r_k          <= addr[1:0];
                r_rt_old     <= rt_old;
                r_address    <= {addr[31:2], 2'b00};
                r_byteenable <= w_be;
                r_writedata  <= store_data << {addr[1:0], 3'b000};
            end
            if (w_last) begin
                r_load_result <= w_aligned;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        busy       = 1'b1;
        done       = 1'b0;
        addr_error = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = op_misaligned(op, addr[1:0]) ? ERR : REQ;
                end
            end
            REQ: begin
                read  = !op_is_store(r_op);
                write = op_is_store(r_op);
                if (!waitrequest) begin
                    w_next = op_is_store(r_op) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            ERR: begin
                done       = 1'b1;
                addr_error = 1'b1;
                w_next     = IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

    load_align u_load_align (
        .op          (r_op),
        .k           (r_k),
        .readdata    (readdata),
        .rt_old      (r_rt_old),
        .load_result (w_aligned)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_access_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_master
// Purpose  : Self-checking bench for mem_access_master with a byte-level RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_master;
    import mem_pkg::*;

    localparam int RL  = 1;
    localparam int RL3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, waitrequest;
    mem_op_t     op;
    logic [31:0] addr, store_data, rt_old, readdata;
    logic        busy, done, addr_error, read, write;
    logic [31:0] load_result, address, writedata;
    logic [3:0]  byteenable;

    logic        reset3, start3;
    logic        waitrequest3 = 1'b0;
    mem_op_t     op3;
    logic [31:0] addr3, readdata3;
    logic        busy3, done3, err3, read3, write3;
    logic [31:0] lr3, address3, writedata3;
    logic [3:0]  be3;

    mem_access_master #(.READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
        .store_data(store_data), .rt_old(rt_old), .busy(busy), .done(done),
        .addr_error(addr_error), .load_result(load_result), .address(address),
        .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    mem_access_master #(.READ_LATENCY(RL3)) dut3 (
        .clk(clk), .reset(reset3), .start(start3), .op(op3), .addr(addr3),
        .store_data(store_data), .rt_old(rt_old), .busy(busy3), .done(done3),
        .addr_error(err3), .load_result(lr3), .address(address3),
        .byteenable(be3), .read(read3), .write(write3), .writedata(writedata3),
        .waitrequest(waitrequest3), .readdata(readdata3)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus-side RAM driven by the DUTs, and an independent reference copy
    logic [7:0] ram [0:511];
    logic [7:0] mdl [0:511];

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {ram[{a[8:2], 2'd3}], ram[{a[8:2], 2'd2}], ram[{a[8:2], 2'd1}], ram[{a[8:2], 2'd0}]};
    endfunction

    function automatic logic [7:0] mb(input int i);
        return mdl[9'(i)];
    endfunction

    int          pend_cyc  = -1;
    logic [31:0] pend_addr = '0;
    always @(negedge clk) begin
        readdata = (cyc == pend_cyc) ? ram_word(pend_addr) : 32'hDEADBEEF;
        if (read && !waitrequest) begin
            pend_cyc  = cyc + RL;
            pend_addr = address;
        end
        if (write && !waitrequest)
            for (int n = 0; n < 4; n++)
                if (byteenable[n]) ram[{address[8:2], 2'(n)}] = writedata[8*n +: 8];
    end

    int          pend3      = -1;
    logic [31:0] pend3_addr = '0;
    always @(negedge clk) begin
        readdata3 = (cyc == pend3) ? ram_word(pend3_addr) : 32'hDEADBEEF;
        if (read3) begin
            pend3      = cyc + RL3;
            pend3_addr = address3;
        end
    end

    function automatic logic [3:0] model_be(input mem_op_t o, input int k);
        logic [3:0] be;
        be = '0;
        for (int n = 0; n < 4; n++) begin
            case (o)
                OP_LB, OP_LBU, OP_SB: be[n] = (n == k);
                OP_LH, OP_LHU, OP_SH: be[n] = (n == k) || (n == k + 1);
                OP_LWL:               be[n] = (n <= k);
                OP_LWR:               be[n] = (n >= k);
                default:              be[n] = 1'b1;
            endcase
        end
        return be;
    endfunction

    function automatic logic model_err(input mem_op_t o, input int k);
        if (o inside {OP_LH, OP_LHU, OP_SH}) return (k % 2) != 0;
        if (o inside {OP_LW, OP_SW}) return k != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input mem_op_t o, input logic [31:0] a, input logic [31:0] rt);
        int base, k;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        base = int'({a[8:2], 2'b00});
        k    = int'(a[1:0]);
        b    = mb(base + k);
        h    = {mb(base + k + 1), mb(base + k)};
        r    = rt;
        case (o)
            OP_LB:  r = {{24{b[7]}}, b};
            OP_LBU: r = {24'h0, b};
            OP_LH:  r = {{16{h[15]}}, h};
            OP_LHU: r = {16'h0, h};
            OP_LW:  r = {mb(base + 3), mb(base + 2), mb(base + 1), mb(base)};
            OP_LWL: for (int i = 0; i < 4; i++) if (i >= 3 - k) r[8*i +: 8] = mb(base + i - (3 - k));
            OP_LWR: for (int i = 0; i < 4; i++) if (i <= 3 - k) r[8*i +: 8] = mb(base + k + i);
            default: r = rt;
        endcase
        return r;
    endfunction

    // Expected transaction, expressed as a timeline relative to the start cycle
    logic        m_active = 1'b0;
    int          m_start  = 0;
    int          m_done_t = 0;
    int          m_nwait  = 0;
    logic        m_err    = 1'b0;
    logic        m_store  = 1'b0;
    logic [31:0] m_addr   = '0;
    logic [3:0]  m_be     = '0;
    logic [31:0] m_wd     = '0;
    logic [31:0] m_new_lr = '0;
    logic [31:0] m_lr     = '0;
    logic [3:0]  obs_be;
    logic [31:0] obs_wd;

    always @(negedge clk) begin : p_compare
        int   t;
        logic bus;
        t   = cyc - m_start;
        bus = m_active && !m_err && (t >= 1) && (t <= 1 + m_nwait);
        if (m_active && (t == m_done_t) && !m_store && !m_err) m_lr = m_new_lr;
        if (chk_en) begin
            check_bit("busy", busy, m_active && (t >= 1) && (t <= m_done_t));
            check_bit("done", done, m_active && (t == m_done_t));
            check_bit("addr_error", addr_error, m_active && m_err && (t == m_done_t));
            check_bit("read", read, bus && !m_store);
            check_bit("write", write, bus && m_store);
            check("load_result", load_result, m_lr);
            if (bus) begin
                check("address", address, {m_addr[31:2], 2'b00});
                check("byteenable", {28'h0, byteenable}, {28'h0, m_be});
                if (m_store) check("writedata", writedata, m_wd);
                obs_be = byteenable;
                obs_wd = writedata;
            end
        end
    end

    task automatic issue(input mem_op_t o, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rt, input int nwait, input logic restart,
                         input logic [3:0] lit_be, input logic [31:0] lit_val);
        int k;
        @(posedge clk); #1;
        k        = int'(a[1:0]);
        obs_be   = 'x;
        obs_wd   = 'x;
        m_addr   = a;
        m_nwait  = nwait;
        m_err    = model_err(o, k);
        m_store  = (o inside {OP_SB, OP_SH, OP_SW});
        m_be     = model_be(o, k);
        for (int n = 0; n < 4; n++) m_wd[8*n +: 8] = (n >= k) ? sd[8*(n - k) +: 8] : 8'h00;
        m_new_lr = (m_store || m_err) ? m_lr : model_load(o, a, rt);
        if (m_store && !m_err)
            for (int n = 0; n < 4; n++) if (m_be[n]) mdl[9'({a[8:2], 2'b00} + n)] = sd[8*(n - k) +: 8];
        m_done_t = m_err ? 1 : (m_store ? 2 + nwait : 2 + nwait + RL);
        m_start  = cyc;
        m_active = 1'b1;
        start = 1'b1; op = o; addr = a; store_data = sd; rt_old = rt;
        waitrequest = (nwait > 0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (nwait) begin @(posedge clk); #1; end
        waitrequest = 1'b0;
        while (cyc < m_start + m_done_t) begin @(posedge clk); #1; end
        if (restart) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        while (cyc < m_start + m_done_t + 2) begin @(posedge clk); #1; end
        if (!m_err) check("lit_byteenable", {28'h0, obs_be}, {28'h0, lit_be});
        if (m_store && !m_err) check("lit_writedata", obs_wd, lit_val);
        else check("lit_load_result", load_result, lit_val);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = OP_LB; addr = '0; store_data = '0; rt_old = '0;
        waitrequest = 1'b0;
        reset3 = 1'b1; start3 = 1'b0; op3 = OP_LW; addr3 = '0;
        for (int i = 0; i < 512; i++) begin ram[i] = 8'h00; mdl[i] = 8'h00; end
        ram[256] = 8'hBB; ram[257] = 8'hAA; ram[258] = 8'h99; ram[259] = 8'h88;
        mdl[256] = 8'hBB; mdl[257] = 8'hAA; mdl[258] = 8'h99; mdl[259] = 8'h88;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; reset3 = 1'b0;
        @(negedge clk);
        check("rst_address", address, 32'h0);
        check("rst_byteenable", {28'h0, byteenable}, 32'h0);
        check("rst_writedata", writedata, 32'h0);
        check("rst_load_result", load_result, 32'h0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_read", read, 1'b0);
        check_bit("rst_write", write, 1'b0);
        chk_en = 1'b1;

        issue(OP_LB,  32'h103, 32'h0,        32'h0,        0, 1'b0, 4'b1000, 32'hFFFFFF88);
        issue(OP_LBU, 32'h103, 32'h0,        32'h0,        0, 1'b0, 4'b1000, 32'h00000088);
        issue(OP_LWL, 32'h101, 32'h0,        32'h11223344, 0, 1'b0, 4'b0011, 32'hAABB3344);
        issue(OP_LWR, 32'h101, 32'h0,        32'h11223344, 0, 1'b0, 4'b1110, 32'h118899AA);
        issue(OP_SH,  32'h102, 32'h00001234, 32'h0,        0, 1'b0, 4'b1100, 32'h12340000);
        issue(OP_LW,  32'h100, 32'h0,        32'h0,        0, 1'b0, 4'b1111, 32'h1234AABB);
        issue(OP_LW,  32'h100, 32'h0,        32'h0,        3, 1'b0, 4'b1111, 32'h1234AABB);
        issue(OP_LW,  32'h102, 32'h0,        32'h0,        0, 1'b0, 4'b0000, 32'h1234AABB);
        issue(OP_SB,  32'h101, 32'h000000C7, 32'h0,        0, 1'b1, 4'b0010, 32'h0000C700);
        issue(OP_LH,  32'h100, 32'h0,        32'h0,        0, 1'b0, 4'b0011, 32'hFFFFC7BB);
        issue(OP_LHU, 32'h102, 32'h0,        32'h0,        0, 1'b0, 4'b1100, 32'h00001234);
        issue(OP_SH,  32'h101, 32'h00005555, 32'h0,        0, 1'b0, 4'b0000, 32'h00001234);
        issue(OP_SW,  32'h100, 32'hCAFEF00D, 32'h0,        2, 1'b0, 4'b1111, 32'hCAFEF00D);
        issue(OP_LWL, 32'h103, 32'h0,        32'h11223344, 0, 1'b0, 4'b1111, 32'hCAFEF00D);
        issue(OP_LWR, 32'h103, 32'h0,        32'h11223344, 0, 1'b0, 4'b1000, 32'h112233CA);
        issue(OP_LB,  32'h100, 32'h0,        32'h0,        0, 1'b0, 4'b0001, 32'h0000000D);

        // Three-cycle read latency: full read, then reset while waiting on data
        @(posedge clk); #1;
        start3 = 1'b1; op3 = OP_LW; addr3 = 32'h100;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            @(negedge clk);
            check_bit("rl3_done", done3, t == 5);
            check_bit("rl3_read", read3, t == 1);
            check_bit("rl3_write", write3, 1'b0);
            if (t == 5) check("rl3_load_result", lr3, 32'hCAFEF00D);
            @(posedge clk); #1;
        end
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        @(posedge clk); #1;
        reset3 = 1'b1;
        @(negedge clk);
        check_bit("rl3_busy_in_wait", busy3, 1'b1);
        @(posedge clk); #1;
        reset3 = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            check_bit("rl3_rst_busy", busy3, 1'b0);
            check_bit("rl3_rst_read", read3, 1'b0);
            check_bit("rl3_rst_done", done3, 1'b0);
            check("rl3_rst_load_result", lr3, 32'h0);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
